// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the byte-serial subtractor.
//   SUB_SEQ_NBYTES_DEF : default operand width in bytes
//   state_t            : controller states IDLE / RUN / DONE
package sub_seq_pkg;

    localparam int unsigned SUB_SEQ_NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_seq_ctrl_if.sv
// Handshake bundle for sub_seq_ctrl.
//   in_valid/in_ready   : operand offer / accept
//   a, b, bin           : minuend, subtrahend, initial borrow-in
//   out_valid/out_ready : result offer / accept
//   diff, bout          : result and final borrow-out
//   busy                : operation in progress (RUN or DONE)
// Modports: master drives operands and consumes results, slave is the subtractor.
interface sub_seq_ctrl_if
    import sub_seq_pkg::*;
#(
    parameter int unsigned NBYTES = SUB_SEQ_NBYTES_DEF
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   diff;
    logic                  bout;
    logic                  busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );

endinterface

// File: rtl/sub_byte_stage.sv
// Purely combinational 8-bit borrow-subtract stage.
//   a, b : byte operands
//   bin  : borrow-in
//   d    : (a - b - bin) mod 256
//   bout : 1 when a < b + bin
module sub_byte_stage (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic [7:0] d,
    output logic       bout
);

    logic [8:0] full;

    // Bit 8 of the 9-bit two's-complement result is set exactly when it went negative.
    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        d    = full[7:0];
        bout = full[8];
    end

endmodule

// File: rtl/sub_seq_ctrl.sv
// Byte-serial subtractor: diff = (a - b - bin) mod 2^(8*NBYTES), one byte per
// cycle through a single shared sub_byte_stage, LSB first.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sub_seq_ctrl_if.slave handshake bundle
//   zero  : (only with SUB_SEQ_ZERO_FLAG_EN) 1 in DONE iff diff == 0
// Result appears NBYTES cycles after the accepting edge and is held until out_ready.
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int unsigned NBYTES = SUB_SEQ_NBYTES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    sub_seq_ctrl_if.slave bus
`ifdef SUB_SEQ_ZERO_FLAG_EN
    ,
    output logic          zero
`endif
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            borrow_q, borrow_d;

    logic [7:0]      a_byte, b_byte, stage_d;
    logic            stage_bout;

    assign a_byte = a_q[8*k_q +: 8];
    assign b_byte = b_q[8*k_q +: 8];

    sub_byte_stage u_stage (
        .a    (a_byte),
        .b    (b_byte),
        .bin  (borrow_q),
        .d    (stage_d),
        .bout (stage_bout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (k_q == KLAST)  state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.diff      = diff_q;
        bus.bout      = borrow_q;
    end

    // Datapath next-state
    always_comb begin
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    k_d      = '0;
                end
            end
            RUN: begin
                diff_d[8*k_q +: 8] = stage_d;
                borrow_d           = stage_bout;
                // k parks on the last byte; only a new accept clears it.
                if (k_q != KLAST) k_d = k_q + KW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SUB_SEQ_ZERO_FLAG_EN
    // Sticky "some written byte was non-zero" flag.
    logic nz_q, nz_d;

    always_comb begin
        nz_d = nz_q;
        if (state_q == IDLE && bus.in_valid) nz_d = 1'b0;
        else if (state_q == RUN)             nz_d = nz_q | (|stage_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) nz_q <= 1'b0;
        else        nz_q <= nz_d;
    end

    assign zero = (state_q == DONE) && !nz_q;
`endif

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (NBYTES = 4): directed cases, hold/back-pressure,
// mid-operation reset and randomized operands against an arithmetic reference.
module tb_sub_seq_ctrl;
    import sub_seq_pkg::*;

    localparam int unsigned NB = SUB_SEQ_NBYTES_DEF;
    localparam int unsigned W  = 8 * NB;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sub_seq_ctrl_if #(.NBYTES(NB)) bus ();

`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic zero;
    sub_seq_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .zero  (zero)
    );
`else
    sub_seq_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operand.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        longint unsigned av = 64'(a);
        longint unsigned bv = 64'(b);
        longint unsigned r  = av - bv - 64'(bin);
        logic            br = (av < bv + 64'(bin));
        return {br, r[W-1:0]};
    endfunction

    // One full transaction. Entry: #1 after a rising edge, block in IDLE.
    // During 'hold' DONE cycles and the release edge, offer operand p* with in_valid=1
    // if keep_p is set; it must not be captured before the block returns to IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int hold, input logic keep_p,
                          input logic [W-1:0] pa, input logic [W-1:0] pb, input logic pbin);
        logic [W:0] exp;
        int         n;
        exp = ref_sub(a, b, bin);
        check("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.bin = 1'($urandom);
        check("busy_run", bus.busy, 1'b1);
        check("in_ready_run", bus.in_ready, 1'b0);
        n = 0;
        while (!bus.out_valid && n < int'(NB) + 4) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(NB));
        check("diff", 64'(bus.diff), 64'(exp[W-1:0]));
        check("bout", bus.bout, exp[W]);
`ifdef SUB_SEQ_ZERO_FLAG_EN
        check("zero", zero, exp[W-1:0] == '0);
`endif
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = keep_p;
            bus.a = pa;
            bus.b = pb;
            bus.bin = pbin;
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_diff", 64'(bus.diff), 64'(exp[W-1:0]));
            check("hold_bout", bus.bout, exp[W]);
        end
        bus.in_valid = keep_p;
        bus.a = pa;
        bus.b = pb;
        bus.bin = pbin;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", bus.out_valid, 1'b0);
        check("release_busy", bus.busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_diff", 64'(bus.diff), 64'd0);
        check("rst_bout", bus.bout, 1'b0);
        rst_n = 1'b1;

        // Directed cases
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1, 1'b0, '0, '0, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0000, 1'b1, 0, 1'b0, '0, '0, 1'b0);

        // Back-pressure in DONE with a competing offer, then that offer is taken from IDLE
        run_op(32'hFFFF_0000, 32'h0001_0001, 1'b0, 3, 1'b1, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b1);
        run_op(32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b1, 0, 1'b0, '0, '0, 1'b0);

        // Reset after two RUN cycles discards the operation
        bus.in_valid = 1'b1;
        bus.a = 32'h8000_0000;
        bus.b = 32'h0000_0003;
        bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_diff", 64'(bus.diff), 64'd0);
        for (int i = 0; i < int'(NB) + 4; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", bus.out_valid, 1'b0);
        end

`ifdef SUB_SEQ_ZERO_FLAG_EN
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_op(32'hDEAD_BEF0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, '0, '0, 1'b0);
`endif

        // Randomized operands
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = (i % 4 == 0) ? ra : W'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sub_seq_ctrl.md
SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4: operand width in bytes, legal range 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1: the block can accept an operand set.
REQ-006 SHALL have port a, input, 8*NBYTES: minuend.
REQ-007 SHALL have port b, input, 8*NBYTES: subtrahend.
REQ-008 SHALL have port bin, input, 1: initial borrow-in.
REQ-009 SHALL have port out_valid, output, 1: the result is valid.
REQ-010 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-011 SHALL have port diff, output, 8*NBYTES: the result, (a - b - bin) mod 2^(8*NBYTES).
REQ-012 SHALL have port bout, output, 1: final borrow-out, 1 when a < b + bin.
REQ-013 SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE when in_valid=1, register a, b and bin, clear the byte index k to 0, and move to RUN.
REQ-017 SHALL, in each RUN cycle, feed byte k of a, byte k of b and the borrow register into one shared 8-bit borrow-subtract stage.
REQ-018 SHALL write that stage's difference into diff byte k and its borrow-out into the borrow register.
REQ-019 SHALL increment k by 1 per RUN cycle, process byte 0 (LSB) first, and move to DONE after byte NBYTES-1.
REQ-020 SHALL assert out_valid exactly NBYTES cycles after the accepting edge.
REQ-021 SHALL drive bout equal to the borrow register in DONE.
REQ-022 SHALL hold out_valid, diff and bout stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-023 SHALL ignore in_valid in RUN and DONE; no operand is captured or lost silently, since in_ready=0.
REQ-024 SHALL not accept in the cycle out_ready completes DONE; minimum accept-to-accept interval is NBYTES+2 cycles.
REQ-025 SHALL have k wrap to 0 only via IDLE; k never exceeds NBYTES-1.
REQ-026 SHALL hold diff at the previous result outside DONE; diff is defined only while out_valid=1.

Reset
REQ-027 SHALL, on clk edge with rst_n=0, set state to IDLE, k to 0, the borrow register to 0, diff to 0 and bout to 0.
REQ-028 SHALL, after reset, drive in_ready=1, out_valid=0 and busy=0.
REQ-029 SHALL, on reset in RUN or DONE, discard the operation in progress with no out_valid pulse.

Configuration
REQ-030 SHALL, with macro SUB_SEQ_ZERO_FLAG_EN defined, add output port zero (1 bit).
REQ-031 SHALL, with SUB_SEQ_ZERO_FLAG_EN defined, accumulate zero by ORing each byte as written during RUN, and drive zero=1 in DONE iff diff==0.
REQ-032 SHALL reset zero to 0 when SUB_SEQ_ZERO_FLAG_EN is defined.
REQ-033 SHALL, with SUB_SEQ_ZERO_FLAG_EN undefined, have no zero port and no zero accumulation logic.

Structure
REQ-034 SHALL place the state enum typedef (IDLE/RUN/DONE) and the constant SUB_SEQ_NBYTES_DEF=4 in package sub_seq_pkg.
REQ-035 SHALL instantiate the 8-bit borrow-subtract stage as sub-module sub_byte_stage (a[7:0], b[7:0], bin -> d[7:0], bout), which is purely combinational.
REQ-036 SHALL hold all control state in sub_seq_ctrl.

Verification (NBYTES=4)
REQ-037 SHALL cover: a=0x00000100, b=0x00000001, bin=0 -> diff=0x000000FF, bout=0, out_valid 4 cycles after accept.
REQ-038 SHALL cover: a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1 (borrow ripples through all bytes).
REQ-039 SHALL cover: a=0x12345678, b=0x00000000, bin=1 -> diff=0x12345677, bout=0.
REQ-040 SHALL cover: out_ready held 0 for 3 cycles in DONE with in_valid=1 -> diff and bout stable, in_ready=0, the new operand is not captured; accepted only after return to IDLE.
REQ-041 SHALL cover: rst_n=0 after 2 RUN cycles -> next cycle in_ready=1, out_valid=0, busy=0, diff=0, and no spurious result afterwards.
REQ-042 SHALL cover, with SUB_SEQ_ZERO_FLAG_EN defined: a=b=0xDEADBEEF, bin=0 -> diff=0, zero=1, bout=0; a=0xDEADBEF0 -> zero=0.
